lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the word-addressed data memory.
- Accepts one byte, halfword or word access per request. Converts byte addresses to word indices. Performs read-modify-write for sub-word stores. Sign- or zero-extends sub-word loads.
- Flags misaligned and out-of-range accesses.
- Enforces the data memory rules: word 0 always reads 0 and is never written.

Parameters:
- AWIDTH, 32, data/address width.
- ALENGTH, 128, number of 32-bit words in data memory.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  execute stage presents a request.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_signed  input  1  sign-extend sub-word load.
- req_addr  input  AWIDTH  byte address.
- req_wdata  input  AWIDTH  store data, right-aligned.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  AWIDTH  load result (0 for stores and errors).
- rsp_err  output  1  misaligned, reserved size, or out of range.
- dm_we  output  1  data memory write enable.
- dm_addr  output  AWIDTH  word index = {2'b0, addr[AWIDTH-1:2]}.
- dm_wdata  output  AWIDTH  word written to memory.
- dm_rdata  input  AWIDTH  memory read data, combinational from dm_addr.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - dm_we = 0, dm_addr = 0, dm_wdata = 0.
  - All captured request registers cleared.
- Reset mid-operation aborts the access. No write may occur after rst_n falls.
- Accept: on the req_valid & req_ready edge, capture store, size, signed, addr and wdata. Inputs are ignored outside IDLE.
- Error check at accept:
  - err if size = 11, size = 01 with addr[0] = 1, size = 10 with addr[1:0] != 0, or addr[AWIDTH-1:2] >= ALENGTH.
  - Error path: IDLE -> RESP with rsp_err = 1 and rsp_rdata = 0. The memory is never written.
- FSM states and transitions:
  - IDLE: word load -> READ; sub-word load -> READ; word store -> WRITE; sub-word store -> READ.
  - READ: one cycle. dm_addr is driven and dm_rdata is captured at the end of the cycle. Load -> RESP. Sub-word store -> WRITE with the merged word.
  - WRITE: one cycle with dm_we = 1, then -> RESP.
  - RESP: rsp_valid = 1. Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1, then -> IDLE.
- Latency from accept to first rsp_valid: word load 2 cycles; word store 2; sub-word store 3; error 1.
- A new request can be accepted in the cycle after the response handshake.
- Load extraction:
  - Byte lane = addr[1:0]. Half lane = addr[1].
  - Zero-extend, or sign-extend from bit 7 / bit 15 when req_signed = 1.
  - Word loads ignore req_signed.
- Store merge: replace only the addressed byte or half of the captured old word with the low 8/16 bits of wdata. Other bytes are preserved bit-exact.
- Word index 0:
  - dm_we is never asserted when dm_addr = 0. The store still completes with rsp_err = 0.
  - Loads from index 0 return 0, independent of dm_rdata.
- dm_we is 0 in every state except WRITE. dm_addr holds its last value when not in use.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x10 -> dm_we pulses once with dm_addr = 4 and dm_wdata = 0xDEADBEEF; rsp_valid 2 cycles after accept. Load 0x10 -> rsp_rdata = 0xDEADBEEF.
- Byte store RMW: memory word 4 = 0x11223344; store byte 0xAA to addr 0x11 -> dm_wdata = 0x1122AA44; 3-cycle latency; other bytes unchanged.
- Sign extension: word 4 = 0x80F0_7F85. Signed byte load at 0x10 -> 0xFFFFFF85. Unsigned -> 0x00000085. Signed half at 0x12 -> 0xFFFF80F0.
- Errors: word load at 0x13, half store at 0x21, size = 11, and word access at addr 0x200 (index 128) -> rsp_err = 1 one cycle after accept; rsp_rdata = 0; dm_we never asserts.
- Index 0 protection: store 0x12345678 to addr 0x0 -> dm_we stays 0; rsp_err = 0. Load 0x0 with dm_rdata forced to 0xFFFFFFFF -> rsp_rdata = 0.
- Backpressure and reset: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, new req_valid ignored. Assert rst_n low during WRITE of a sub-word store -> dm_we drops immediately, req_ready = 1, rsp_valid = 0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store unit sitting between the execute stage and a word-addressed
//   data memory. One byte, halfword or word access per request. Byte addresses
//   are turned into word indices, sub-word stores are done as read-modify-write,
//   and sub-word loads are zero- or sign-extended. Misaligned, reserved-size and
//   out-of-range accesses complete as error responses without touching memory.
//   Word index 0 reads as zero and is never written.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_store          1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 reserved
//   req_signed         sign-extend sub-word loads
//   req_addr           byte address
//   req_wdata          store data, right-aligned
//   rsp_valid/ready    response handshake
//   rsp_rdata          load result (0 for stores and errors)
//   rsp_err            access rejected
//   dm_we/addr/wdata   data memory write enable, word index, write word
//   dm_rdata           data memory read word, combinational from dm_addr
// -----------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int AWIDTH  = 32,
   parameter int ALENGTH = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [AWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [AWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              dm_we,
   output logic [AWIDTH-1:0] dm_addr,
   output logic [AWIDTH-1:0] dm_wdata,
   input  logic [AWIDTH-1:0] dm_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [AWIDTH-1:0] ALEN_W = AWIDTH'(ALENGTH);

   state_t            state_q;
   logic              store_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [1:0]        lane_q;      // addr[1:0] of the captured request
   logic [15:0]       wdata_lo_q;  // only the low half is needed after accept
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [AWIDTH-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              dm_we_q;
   logic [AWIDTH-1:0] dm_addr_q;
   logic [AWIDTH-1:0] dm_wdata_q;

   // Request decode, evaluated only while idle.
   logic [AWIDTH-1:0] req_idx;
   logic              req_err;

   assign req_idx = {2'b00, req_addr[AWIDTH-1:2]};
   assign req_err = (req_size == SZ_RSVD)
                  | ((req_size == SZ_HALF) & req_addr[0])
                  | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                  | (req_idx >= ALEN_W);

   // Load extraction and store merge, both working on the live memory word
   // during the READ cycle.
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [AWIDTH-1:0] ld_data;
   logic [AWIDTH-1:0] st_merge;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned (which would infer a latch).
   always_comb begin
      ld_byte  = dm_rdata[{lane_q, 3'b000} +: 8];
      ld_half  = dm_rdata[{lane_q[1], 4'b0000} +: 16];
      ld_data  = dm_rdata;
      st_merge = dm_rdata;
      unique case (size_q)
         SZ_BYTE: begin
            ld_data = {{(AWIDTH-8){signed_q & ld_byte[7]}}, ld_byte};
            st_merge[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
         end
         SZ_HALF: begin
            ld_data = {{(AWIDTH-16){signed_q & ld_half[15]}}, ld_half};
            st_merge[{lane_q[1], 4'b0000} +: 16] = wdata_lo_q;
         end
         default: ;  // word: passes through unchanged
      endcase
   end

   // Single FSM block; all outputs are registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         store_q     <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         lane_q      <= 2'b00;
         wdata_lo_q  <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= '0;
         dm_wdata_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  store_q     <= req_store;
                  size_q      <= req_size;
                  signed_q    <= req_signed;
                  lane_q      <= req_addr[1:0];
                  wdata_lo_q  <= req_wdata[15:0];
                  req_ready_q <= 1'b0;
                  if (req_err) begin
                     // Rejected: answer next cycle, memory untouched.
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     dm_addr_q <= req_idx;
                     if (req_store && (req_size == SZ_WORD)) begin
                        // Full-word store needs no read of the old word.
                        state_q    <= S_WRITE;
                        dm_wdata_q <= req_wdata;
                        dm_we_q    <= (req_idx != '0);
                     end else begin
                        state_q <= S_READ;
                     end
                  end
               end
            end

            S_READ: begin
               if (store_q) begin
                  state_q    <= S_WRITE;
                  dm_wdata_q <= st_merge;
                  dm_we_q    <= (dm_addr_q != '0);
               end else begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  // Word 0 is hard-wired to read as zero.
                  rsp_rdata_q <= (dm_addr_q == '0) ? '0 : ld_data;
               end
            end

            S_WRITE: begin
               state_q     <= S_RESP;
               dm_we_q     <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end

            S_RESP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
                  req_ready_q <= 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dm_we     = dm_we_q;
   assign dm_addr   = dm_addr_q;
   assign dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl. A behavioural 128-word memory answers
//   dm_addr combinationally and records writes. A table of request vectors is
//   applied in order; the expected response is queued on accept and compared
//   when rsp_valid appears, together with latency and observed memory writes.
//   Backpressure and reset-during-write are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

   localparam int AW = 32;
   localparam int AL = 128;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_store;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [AW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [AW-1:0] dm_wdata;
   logic [AW-1:0] dm_rdata;

   lsu_ctrl #(.AWIDTH(AW), .ALENGTH(AL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model
   logic [AW-1:0] mem [AL] = '{default: '0};
   logic          force1 = 1'b0;
   int            wr_cnt = 0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] wr_data = '0;

   assign dm_rdata = force1 ? '1 : ((dm_addr < AL) ? mem[dm_addr[6:0]] : '0);

   always @(posedge clk) begin
      if (dm_we) begin
         wr_cnt  = wr_cnt + 1;
         wr_addr = dm_addr;
         wr_data = dm_wdata;
         if (dm_addr < AL) mem[dm_addr[6:0]] <= dm_wdata;
      end
   end

   // Checking
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   typedef struct {
      logic          store;
      logic [1:0]    size;
      logic          sgn;
      logic [AW-1:0] addr;
      logic [AW-1:0] wdata;
      logic          frc;
      logic [AW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;
      int            exp_wr;
      logic [AW-1:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [AW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic sg,
                               input logic [AW-1:0] a, input logic [AW-1:0] wd,
                               input logic fr, input logic [AW-1:0] er, input logic ee,
                               input int el, input int ew, input logic [AW-1:0] ewd);
      vec_t v;
      v.store = st; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd; v.frc = fr;
      v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_wr = ew; v.exp_wdata = ewd;
      return v;
   endfunction

   // Issues one request with rsp_ready held high and checks everything about it.
   task automatic do_req(input string tag, input vec_t v);
      int   n;
      int   lat;
      int   wr0;
      exp_t e;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      force1     = v.frc;
      req_valid  = 1'b1;
      req_store  = v.store;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      wr0        = wr_cnt;
      e.rdata    = v.exp_rdata;
      e.err      = v.exp_err;
      sb.push_back(e);
      @(posedge clk); #1;
      // Scramble the inputs: the unit must work from its captured copy.
      req_valid  = 1'b0;
      req_store  = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      e = sb.pop_front();
      check({tag, " rdata"}, rsp_rdata, e.rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(e.err));
      check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
      if (v.exp_wr != 0) begin
         check({tag, " wr_addr"}, wr_addr, {2'b00, v.addr[AW-1:2]});
         check({tag, " wr_data"}, wr_data, v.exp_wdata);
      end
      @(posedge clk); #1;
      force1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wr0;
      int lat;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;

      // Stimulus table: store, size, signed, addr, wdata, force, rdata, err, lat, writes, wdata
      vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0, 2, 1, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'h11223344, 0, 32'h0,        0, 2, 1, 32'h11223344));
      vecs.push_back(mk(1, 2'b00, 0, 32'h11,  32'hFFFFFFAA, 0, 32'h0,        0, 3, 1, 32'h1122AA44));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'h1122AA44, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h12,  32'h1234BEEF, 0, 32'h0,        0, 3, 1, 32'hBEEFAA44));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hBEEFAA44, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'h80F07F85, 0, 32'h0,        0, 2, 1, 32'h80F07F85));
      vecs.push_back(mk(0, 2'b00, 1, 32'h10,  32'h0,        0, 32'hFFFFFF85, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h10,  32'h0,        0, 32'h00000085, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b01, 1, 32'h12,  32'h0,        0, 32'hFFFF80F0, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        0, 32'h000080F0, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h11,  32'h0,        0, 32'h0000007F, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h13,  32'h0,        0, 32'hFFFFFF80, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b01, 1, 32'h10,  32'h0,        0, 32'h00007F85, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b10, 1, 32'h10,  32'h0,        0, 32'h80F07F85, 0, 2, 0, 32'h0));
      // Errors
      vecs.push_back(mk(0, 2'b10, 0, 32'h13,  32'h0,        0, 32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, 2'b01, 0, 32'h21,  32'h1111,     0, 32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(0, 2'b11, 0, 32'h20,  32'h0,        0, 32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, 2'b11, 0, 32'h10,  32'h5555AAAA, 0, 32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h200, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, 2'b10, 0, 32'h200, 32'h5A5A5A5A, 0, 32'h0,        1, 1, 0, 32'h0));
      // Last valid word
      vecs.push_back(mk(1, 2'b10, 0, 32'h1FC, 32'h0F0F0F0F, 0, 32'h0,        0, 2, 1, 32'h0F0F0F0F));
      vecs.push_back(mk(0, 2'b10, 0, 32'h1FC, 32'h0,        0, 32'h0F0F0F0F, 0, 2, 0, 32'h0));
      // Word 0 protection
      vecs.push_back(mk(1, 2'b10, 0, 32'h0,   32'h12345678, 0, 32'h0,        0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'b00, 0, 32'h3,   32'h99,       0, 32'h0,        0, 3, 0, 32'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h0,   32'h0,        1, 32'h0,        0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 1, 32'h2,   32'h0,        1, 32'h0,        0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h4,   32'h0,        1, 32'hFFFFFFFF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'h80F07F85, 0, 2, 0, 32'h0));

      // Reset state
      #12;
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'h0);
      check("rst rsp_err",   32'(rsp_err),   32'd0);
      check("rst dm_we",     32'(dm_we),     32'd0);
      check("rst dm_addr",   dm_addr,        32'h0);
      check("rst dm_wdata",  dm_wdata,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         do_req($sformatf("v%0d", i), vecs[i]);
      end

      // Backpressure: response held 5 cycles while a new request is offered.
      rsp_ready  = 1'b0;
      wr0        = wr_cnt;
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'h10;
      @(posedge clk); #1;
      req_store  = 1'b1;
      req_addr   = 32'h14;
      req_wdata  = 32'h0BADBAD0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check("bp latency", 32'(lat), 32'd2);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("bp%0d rsp_rdata", k), rsp_rdata, 32'h80F07F85);
         check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp rsp_valid after", 32'(rsp_valid), 32'd0);
      check("bp req_ready after", 32'(req_ready), 32'd1);
      check("bp writes", 32'(wr_cnt - wr0), 32'd0);

      // Reset during the WRITE cycle of a byte store.
      do_req("pre_rst", mk(1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 0, 32'h0, 0, 2, 1, 32'hCAFEF00D));
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h14;
      req_wdata  = 32'h55;
      @(posedge clk); #1;          // accepted, READ
      req_valid = 1'b0;
      @(posedge clk); #1;          // WRITE
      check("rw dm_we",    32'(dm_we), 32'd1);
      check("rw dm_addr",  dm_addr,    32'h5);
      check("rw dm_wdata", dm_wdata,   32'hCAFEF055);
      wr0 = wr_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid dm_we",     32'(dm_we),     32'd0);
      check("rst_mid req_ready", 32'(req_ready), 32'd1);
      check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("rst_mid writes", 32'(wr_cnt - wr0), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req("post_rst", mk(0, 2'b10, 0, 32'h14, 32'h0, 0, 32'hCAFEF00D, 0, 2, 0, 32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
